// File: rtl/decoder3_8_grant.sv
// Registered 3-to-8 grant decoder fed by a priority encoder's code/valid pair.
// Holds a one-hot grant until ack, abort (EI low) or hold-timer expiry.
module decoder3_8_grant #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EI,
    input  logic [2:0]       Y,
    input  logic             GS,
    input  logic             ack,
    output logic [7:0]       O,
    output logic             valid,
    output logic             timeout,
    output logic [2:0]       last_code,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [7:0]       o_q, o_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       last_code_q, last_code_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [7:0]       timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            o_q         <= 8'h00;
            timeout_q   <= 1'b0;
            last_code_q <= 3'd0;
            grant_cnt_q <= '0;
            timer_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            o_q         <= o_d;
            timeout_q   <= timeout_d;
            last_code_q <= last_code_d;
            grant_cnt_q <= grant_cnt_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_d         = o_q;
        timeout_d   = 1'b0;
        last_code_d = last_code_q;
        grant_cnt_d = grant_cnt_q;
        timer_d     = timer_q;

        case (state_q)
            IDLE: begin
                o_d     = 8'h00;
                timer_d = 8'd0;
                if (EI && GS) begin
                    o_d         = 8'h01 << Y;
                    last_code_d = Y;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Abort beats ack, and ack beats timer expiry.
                if (!EI) begin
                    o_d     = 8'h00;
                    state_d = IDLE;
                end else if (ack) begin
                    o_d         = 8'h00;
                    grant_cnt_d = grant_cnt_q + CNT_W'(1);
                    state_d     = GAP;
                end else if (timer_q == TIMER_LAST) begin
                    o_d       = 8'h00;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            GAP: begin
                o_d     = 8'h00;
                timer_d = 8'd0;
                state_d = IDLE;
            end
            default: begin
                o_d     = 8'h00;
                timer_d = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign O         = o_q;
    assign valid     = (state_q == GRANT);
    assign timeout   = timeout_q;
    assign last_code = last_code_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_decoder3_8_grant.sv
// Directed bench for decoder3_8_grant: hand-computed grant, release, timeout,
// collision, reset and counter-wrap vectors.
module tb_decoder3_8_grant;

    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst_n;
    logic             EI;
    logic [2:0]       Y;
    logic             GS;
    logic             ack;
    logic [7:0]       O;
    logic             valid;
    logic             timeout;
    logic [2:0]       last_code;
    logic [CNT_W-1:0] grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    decoder3_8_grant #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EI       (EI),
        .Y        (Y),
        .GS       (GS),
        .ack      (ack),
        .O        (O),
        .valid    (valid),
        .timeout  (timeout),
        .last_code(last_code),
        .grant_cnt(grant_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock edge; inputs are driven and outputs sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int hi;
    logic [2:0] code;

    initial begin
        rst_n = 1'b0;
        EI    = 1'b0;
        Y     = 3'd0;
        GS    = 1'b0;
        ack   = 1'b0;
        steps(2);
        rst_n = 1'b1;
        check("rst_O", O, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_last_code", last_code, 3'd0);
        check("rst_cnt", grant_cnt, 4'd0);

        // disabled encoder: no grant
        EI = 1'b0; GS = 1'b1; Y = 3'd5;
        step();
        check("dis_O", O, 8'h00);
        check("dis_valid", valid, 1'b0);
        step();
        check("dis_O2", O, 8'h00);

        // basic grant of code 7, ack three cycles later
        EI = 1'b1; GS = 1'b1; Y = 3'd7;
        step();
        check("basic_O", O, 8'h80);
        check("basic_valid", valid, 1'b1);
        check("basic_last_code", last_code, 3'd7);
        GS = 1'b0;
        steps(2);
        check("basic_hold_O", O, 8'h80);
        ack = 1'b1;
        step();
        check("basic_rel_O", O, 8'h00);
        check("basic_rel_valid", valid, 1'b0);
        check("basic_cnt", grant_cnt, 4'd1);
        check("basic_no_timeout", timeout, 1'b0);
        ack = 1'b0; GS = 1'b1; Y = 3'd2;
        step();
        check("gap_O", O, 8'h00);
        step();
        check("regrant_O", O, 8'h04);
        check("regrant_last_code", last_code, 3'd2);
        ack = 1'b1; GS = 1'b0;
        step();
        check("regrant_cnt", grant_cnt, 4'd2);
        ack = 1'b0;
        step();

        // Y/GS changes during GRANT are ignored
        GS = 1'b1; Y = 3'd3;
        step();
        check("inchg_O0", O, 8'h08);
        GS = 1'b0; Y = 3'd6;
        step();
        check("inchg_O1", O, 8'h08);
        GS = 1'b1; Y = 3'd0;
        step();
        check("inchg_O2", O, 8'h08);
        check("inchg_last_code", last_code, 3'd3);
        GS = 1'b0; ack = 1'b1;
        step();
        check("inchg_cnt", grant_cnt, 4'd3);
        ack = 1'b0;
        step();

        // timeout: no ack, grant must stay high for exactly HOLD_MAX cycles
        GS = 1'b1; Y = 3'd1;
        step();
        check("to_O", O, 8'h02);
        hi = 1;
        for (int i = 0; i < 20 && O == 8'h02; i++) begin
            if (timeout !== 1'b0) check("to_early_pulse", timeout, 1'b0);
            step();
            if (O == 8'h02) hi++;
        end
        check("to_high_cycles", hi, HOLD_MAX);
        check("to_rel_O", O, 8'h00);
        check("to_pulse", timeout, 1'b1);
        check("to_cnt", grant_cnt, 4'd3);
        GS = 1'b0;
        step();
        check("to_pulse_end", timeout, 1'b0);
        check("to_idle_O", O, 8'h00);

        // ack on the final hold cycle wins over expiry
        GS = 1'b1; Y = 3'd4;
        step();
        GS = 1'b0;
        steps(HOLD_MAX - 1);
        check("col_last_cycle_O", O, 8'h10);
        ack = 1'b1;
        step();
        check("col_O", O, 8'h00);
        check("col_cnt", grant_cnt, 4'd4);
        check("col_timeout", timeout, 1'b0);
        ack = 1'b0;
        step();
        check("col_timeout2", timeout, 1'b0);

        // EI dropped together with ack: abort wins, no count, straight to IDLE
        GS = 1'b1; Y = 3'd6;
        step();
        check("abort_grant_O", O, 8'h40);
        GS = 1'b0;
        step();
        EI = 1'b0; ack = 1'b1;
        step();
        check("abort_O", O, 8'h00);
        check("abort_valid", valid, 1'b0);
        check("abort_cnt", grant_cnt, 4'd4);
        check("abort_timeout", timeout, 1'b0);
        EI = 1'b1; ack = 1'b0; GS = 1'b1; Y = 3'd5;
        step();
        check("post_abort_O", O, 8'h20);

        // asynchronous reset mid-grant
        GS = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_O", O, 8'h00);
        check("arst_valid", valid, 1'b0);
        check("arst_cnt", grant_cnt, 4'd0);
        check("arst_last_code", last_code, 3'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_idle_O", O, 8'h00);
        GS = 1'b1; Y = 3'd0;
        step();
        check("arst_regrant_O", O, 8'h01);
        GS = 1'b0; ack = 1'b1;
        step();
        check("arst_cnt1", grant_cnt, 4'd1);
        ack = 1'b0;
        step();

        // counter wrap: 15 more acked grants bring 1 back to 0
        for (int i = 1; i < 16; i++) begin
            code = 3'(i);
            GS = 1'b1; Y = code;
            step();
            if (O !== (8'h01 << code)) check("wrap_onehot", O, 8'h01 << code);
            GS = 1'b0; ack = 1'b1;
            step();
            ack = 1'b0;
            if (i == 14) check("wrap_cnt15", grant_cnt, 4'd15);
            step();
        end
        check("wrap_cnt0", grant_cnt, 4'd0);
        check("wrap_last_code", last_code, 3'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
